mem_bus_arbiter: RTL and testbench

- Shares one external memory bus between the IF stage (instruction fetch, read-only) and the MEM stage (data load/store) of the 5-stage RV32I core.
- Sequences each bus transaction with a request/acknowledge handshake: address and control are driven, the block waits for active-low acknowledge, then read data is returned.
- Returns per-requester ready pulses; the pipeline stalls on the inverse of those pulses.
- Data accesses have priority; a starvation counter guarantees instruction fetch progress.

---
 rtl/mem_bus_pkg.sv | 25 ++
 rtl/arb_prio_sel.sv | 33 +++
 rtl/mem_bus_arbiter.sv | 232 +++++++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the IF/MEM external memory bus arbiter.
// Contents:
//   arb_state_e : arbiter FSM encoding (IDLE, GNT_I, GNT_D)
//   gnt_sel_e   : grant choice returned by the priority selector
//   SIZE_*      : bus access size codes; FETCH_SIZE is the size every fetch uses
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_I    = 2'd1,
    SEL_D    = 2'd2
  } gnt_sel_e;

  localparam logic [1:0] SIZE_BYTE  = 2'b00;
  localparam logic [1:0] SIZE_HALF  = 2'b01;
  localparam logic [1:0] SIZE_WORD  = 2'b10;
  localparam logic [1:0] FETCH_SIZE = SIZE_WORD;

endpackage

// File: rtl/arb_prio_sel.sv
// Combinational grant selector for the memory bus arbiter.
// Data accesses win, unless IF is waiting and the run of data grants taken
// while IF waited has reached BURST_MAX, in which case IF is forced through.
// Ports:
//   if_pend_i   : IF request pending (already masked by the caller)
//   d_pend_i    : MEM request pending (already masked by the caller)
//   burst_cnt_i : data grants taken while IF has been waiting
//   sel_o       : grant choice (SEL_NONE / SEL_I / SEL_D)
module arb_prio_sel
  import mem_bus_pkg::*;
#(
  parameter int unsigned BURST_MAX = 4,
  parameter int unsigned CNT_W     = 3
) (
  input  logic             if_pend_i,
  input  logic             d_pend_i,
  input  logic [CNT_W-1:0] burst_cnt_i,
  output gnt_sel_e         sel_o
);

  // Priority decision: data first, bounded by the starvation count.
  always_comb begin
    sel_o = SEL_NONE;
    if (d_pend_i && (!if_pend_i || (burst_cnt_i < CNT_W'(BURST_MAX)))) begin
      sel_o = SEL_D;
    end else if (if_pend_i) begin
      sel_o = SEL_I;
    end else begin
      sel_o = SEL_NONE;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one external memory bus between instruction fetch (read-only) and
// the MEM stage (load/store). Each grant drives address/control, waits for
// the active-low acknowledge, captures read data and pulses the requester's
// ready output for one cycle. All outputs are registered.
// Optional feature macro: ARB_TIMEOUT_EN (acknowledge timeout with sticky bus_err).
// Ports:
//   clk, rst                : clock, asynchronous active-low reset
//   if_req/if_addr          : fetch request and address
//   if_rdata/if_ready       : fetched word and completion pulse
//   d_req/d_we/d_size/d_addr/d_wdata : data request, store flag, size, address, store data
//   d_rdata/d_ready         : load data and completion pulse
//   BAD/BDT_o/BDT_oe/BDT_i  : bus address, write data, write-data enable, read data
//   BREQ/BWRITE/BSIZE/BACK_n: bus request, write, size, acknowledge (active low)
//   bus_err                 : sticky acknowledge-timeout flag (0 when the feature is off)
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int unsigned DATA_BURST_MAX = 4,
  parameter int unsigned TIMEOUT_CYC    = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic [31:0] BAD,
  output logic [31:0] BDT_o,
  output logic        BDT_oe,
  input  logic [31:0] BDT_i,
  output logic        BREQ,
  output logic        BWRITE,
  output logic [1:0]  BSIZE,
  input  logic        BACK_n,
  output logic        bus_err
);

  localparam int unsigned CNT_W = $clog2(DATA_BURST_MAX + 1);

  arb_state_e       state_q, state_d;
  logic [31:0]      bad_q, bad_d, bdt_o_q, bdt_o_d;
  logic [31:0]      if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic             bdt_oe_q, bdt_oe_d, breq_q, breq_d, bwrite_q, bwrite_d;
  logic [1:0]       bsize_q, bsize_d;
  logic             if_ready_q, if_ready_d, d_ready_q, d_ready_d;
  logic [CNT_W-1:0] burst_q, burst_d;
  logic             if_pend_s, d_pend_s, done_s;
  logic [31:0]      fin_data_s;
  gnt_sel_e         sel_s;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYC + 1);
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              bus_err_q, bus_err_d;
`endif

  // The cycle carrying a ready pulse is a dead cycle: the finishing requester
  // is dropping its request, and nobody is granted until the next cycle.
  assign if_pend_s = if_req & ~if_ready_q & ~d_ready_q;
  assign d_pend_s  = d_req  & ~d_ready_q  & ~if_ready_q;

  arb_prio_sel #(
    .BURST_MAX (DATA_BURST_MAX),
    .CNT_W     (CNT_W)
  ) u_prio_sel (
    .if_pend_i   (if_pend_s),
    .d_pend_i    (d_pend_s),
    .burst_cnt_i (burst_q),
    .sel_o       (sel_s)
  );

  // Next-state, bus latch and completion logic.
  always_comb begin
    state_d    = state_q;
    bad_d      = bad_q;
    bdt_o_d    = bdt_o_q;
    bdt_oe_d   = bdt_oe_q;
    breq_d     = breq_q;
    bwrite_d   = bwrite_q;
    bsize_d    = bsize_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_ready_d = 1'b0;
    d_ready_d  = 1'b0;
    burst_d    = burst_q;
    done_s     = 1'b0;
    fin_data_s = BDT_i;
`ifdef ARB_TIMEOUT_EN
    wait_d     = wait_q;
    bus_err_d  = bus_err_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef ARB_TIMEOUT_EN
        wait_d = {WAIT_W{1'b0}};
`endif
        // Starvation count: data grants taken while IF is waiting.
        if (!if_req) begin
          burst_d = {CNT_W{1'b0}};
        end else if (sel_s == SEL_I) begin
          burst_d = {CNT_W{1'b0}};
        end else if ((sel_s == SEL_D) && (burst_q < CNT_W'(DATA_BURST_MAX))) begin
          burst_d = burst_q + CNT_W'(1);
        end else begin
          burst_d = burst_q;
        end
        case (sel_s)
          SEL_D: begin
            state_d  = GNT_D;
            bad_d    = d_addr;
            bsize_d  = d_size;
            bwrite_d = d_we;
            bdt_o_d  = d_wdata;
            bdt_oe_d = d_we;
            breq_d   = 1'b1;
          end
          SEL_I: begin
            state_d  = GNT_I;
            bad_d    = if_addr;
            bsize_d  = FETCH_SIZE;
            bwrite_d = 1'b0;
            bdt_oe_d = 1'b0;
            breq_d   = 1'b1;
          end
          default: state_d = IDLE;
        endcase
      end
      GNT_I, GNT_D: begin
        if (!BACK_n) begin
          done_s     = 1'b1;
          fin_data_s = BDT_i;
`ifdef ARB_TIMEOUT_EN
        end else if (wait_q == WAIT_W'(TIMEOUT_CYC - 1)) begin
          done_s     = 1'b1;
          fin_data_s = 32'h0000_0000;
          bus_err_d  = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
`else
        end else begin
          done_s = 1'b0;
        end
`endif
        if (done_s) begin
          state_d  = IDLE;
          breq_d   = 1'b0;
          bwrite_d = 1'b0;
          bdt_oe_d = 1'b0;
          if (state_q == GNT_I) begin
            if_rdata_d = fin_data_s;
            if_ready_d = 1'b1;
          end else begin
            d_rdata_d = fin_data_s;
            d_ready_d = 1'b1;
          end
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d  = IDLE;
        breq_d   = 1'b0;
        bwrite_d = 1'b0;
        bdt_oe_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      bad_q      <= 32'h0000_0000;
      bdt_o_q    <= 32'h0000_0000;
      bdt_oe_q   <= 1'b0;
      breq_q     <= 1'b0;
      bwrite_q   <= 1'b0;
      bsize_q    <= 2'b00;
      if_rdata_q <= 32'h0000_0000;
      d_rdata_q  <= 32'h0000_0000;
      if_ready_q <= 1'b0;
      d_ready_q  <= 1'b0;
      burst_q    <= {CNT_W{1'b0}};
`ifdef ARB_TIMEOUT_EN
      wait_q     <= {WAIT_W{1'b0}};
      bus_err_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      bad_q      <= bad_d;
      bdt_o_q    <= bdt_o_d;
      bdt_oe_q   <= bdt_oe_d;
      breq_q     <= breq_d;
      bwrite_q   <= bwrite_d;
      bsize_q    <= bsize_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      if_ready_q <= if_ready_d;
      d_ready_q  <= d_ready_d;
      burst_q    <= burst_d;
`ifdef ARB_TIMEOUT_EN
      wait_q     <= wait_d;
      bus_err_q  <= bus_err_d;
`endif
    end
  end

  assign BAD      = bad_q;
  assign BDT_o    = bdt_o_q;
  assign BDT_oe   = bdt_oe_q;
  assign BREQ     = breq_q;
  assign BWRITE   = bwrite_q;
  assign BSIZE    = bsize_q;
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign if_ready = if_ready_q;
  assign d_ready  = d_ready_q;
`ifdef ARB_TIMEOUT_EN
  assign bus_err  = bus_err_q;
`else
  assign bus_err  = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
`timescale 1ns/1ps
module tb_mem_bus_arbiter;

  localparam int BURST = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] if_addr = 32'h0, d_addr = 32'h0, d_wdata = 32'h0, BDT_i = 32'h0;
  logic [1:0]  d_size = 2'b00;
  logic        BACK_n = 1'b1;
  logic [31:0] if_rdata, d_rdata, BAD, BDT_o;
  logic        if_ready, d_ready, BDT_oe, BREQ, BWRITE, bus_err;
  logic [1:0]  BSIZE;

  mem_bus_arbiter #(.DATA_BURST_MAX(BURST), .TIMEOUT_CYC(255)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .BAD(BAD), .BDT_o(BDT_o), .BDT_oe(BDT_oe), .BDT_i(BDT_i),
    .BREQ(BREQ), .BWRITE(BWRITE), .BSIZE(BSIZE), .BACK_n(BACK_n), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  size;
    logic        we;
    logic [31:0] wdata;
  } req_t;

  // Outstanding requests, pushed when each requester raises its request.
  req_t if_q[$], d_q[$];
  req_t if_r, d_r, d_dir, exp_r;
  int   if_left = 0, d_left = 0, gap_max = 0, if_gap = 0, d_gap = 0;
  logic if_fixed = 1'b0, d_fixed = 1'b0;
  logic [31:0] if_dir_addr = 32'h0;
  int unsigned if_issue_cyc = 0, d_issue_cyc = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // IF requester: holds its request until if_ready, then optionally re-issues.
  always @(negedge clk) begin
    if (if_req && if_ready) begin
      if_req = 1'b0;
      if_gap = $urandom_range(gap_max, 0);
    end else if (!if_req && if_left > 0) begin
      if (if_gap > 0) if_gap--;
      else begin
        if_r.addr  = if_fixed ? if_dir_addr : {1'b0, 29'($urandom), 2'b00};
        if_r.size  = 2'b10;
        if_r.we    = 1'b0;
        if_r.wdata = 32'h0;
        if_addr = if_r.addr;
        if_req  = 1'b1;
        if_q.push_back(if_r);
        if_left--;
        if_issue_cyc = cyc;
      end
    end
  end

  // MEM requester: random loads/stores, data addresses tagged with bit 31 set.
  always @(negedge clk) begin
    if (d_req && d_ready) begin
      d_req = 1'b0;
      d_gap = $urandom_range(gap_max, 0);
    end else if (!d_req && d_left > 0) begin
      if (d_gap > 0) d_gap--;
      else begin
        if (d_fixed) d_r = d_dir;
        else begin
          d_r.addr  = {1'b1, 29'($urandom), 2'b00};
          d_r.size  = 2'($urandom_range(2, 0));
          d_r.we    = 1'($urandom_range(1, 0));
          d_r.wdata = $urandom;
        end
        d_addr = d_r.addr; d_size = d_r.size; d_we = d_r.we; d_wdata = d_r.wdata;
        d_req = 1'b1;
        d_q.push_back(d_r);
        d_left--;
        d_issue_cyc = cyc;
      end
    end
  end

  // Bus slave: acknowledges after rtarget wait cycles with BREQ high.
  int   rcnt = 0, rtarget = 0, resp_wait_fix = 0;
  logic resp_rand = 1'b0, resp_fixed = 1'b0;
  logic [31:0] resp_fix_data = 32'h0, last_ack = 32'h0;
  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      BACK_n = 1'b1; rcnt = 0;
      rtarget = resp_rand ? $urandom_range(3, 0) : resp_wait_fix;
    end else if (BREQ && BACK_n) begin
      if (rcnt >= rtarget) begin
        BDT_i = resp_fixed ? resp_fix_data : $urandom;
        last_ack = BDT_i;
        BACK_n = 1'b0;
      end else rcnt++;
    end else begin
      BACK_n = 1'b1; rcnt = 0;
      rtarget = resp_rand ? $urandom_range(3, 0) : resp_wait_fix;
    end
  end

  // Monitor/scoreboard: checks each grant, bus stability and each ready pulse.
  logic breq_prev = 1'b0;
  int   cur_gnt = 0, starve = 0, got;
  logic [97:0] snap;
  string order = "";
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      breq_prev = 1'b0; cur_gnt = 0;
    end else begin
      if (BREQ && !breq_prev) begin
        if (if_q.size() > 0 && (d_q.size() == 0 || !BAD[31])) cur_gnt = 1;
        else if (d_q.size() > 0) cur_gnt = 2;
        else cur_gnt = 0;
        if (cur_gnt == 0) check("grant_without_request", 96'(BREQ), 96'(0));
        else begin
          exp_r = (cur_gnt == 1) ? if_q[0] : d_q[0];
          check("grant_fields",
                {BAD, BSIZE, BWRITE, BDT_oe, (exp_r.we ? BDT_o : 32'h0)},
                {exp_r.addr, exp_r.size, exp_r.we, exp_r.we, (exp_r.we ? exp_r.wdata : 32'h0)});
          order = {order, (cur_gnt == 1) ? "I" : "D"};
          if (cur_gnt == 2 && if_q.size() > 0) begin
            starve++;
            check("if_starvation", 96'(starve <= BURST), 96'(1));
          end
          if (cur_gnt == 1) starve = 0;
        end
        snap = {BAD, BDT_o, BSIZE, BWRITE, BDT_oe};
      end else if (BREQ && breq_prev) begin
        check("bus_stable", 96'({BAD, BDT_o, BSIZE, BWRITE, BDT_oe}), 96'(snap));
      end
      if (if_ready || d_ready) begin
        got = if_ready ? 1 : 2;
        if (if_ready && d_ready) check("dual_ready", 96'(2'b11), 96'(2'b01));
        else if (got != cur_gnt || (got == 1 && if_q.size() == 0) || (got == 2 && d_q.size() == 0))
          check("ready_owner", 96'(got), 96'(cur_gnt));
        else begin
          if (got == 1) begin
            void'(if_q.pop_front());
            check("if_rdata", 96'(if_rdata), 96'(last_ack));
            starve = 0;
          end else begin
            void'(d_q.pop_front());
            check("d_rdata", 96'(d_rdata), 96'(last_ack));
          end
          cur_gnt = 0;
        end
      end
      breq_prev = BREQ;
    end
  end

  task automatic wait_ready(input bit want_d, input int bound, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(posedge clk); #1;
      seen = want_d ? d_ready : if_ready;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL ready_timeout actual=no_pulse expected=pulse within %0d cycles", bound);
    end
  endtask

  task automatic wait_drain(input int bound);
    int n;
    n = 0;
    while ((if_left > 0 || d_left > 0 || if_q.size() > 0 || d_q.size() > 0) && n < bound) begin
      @(posedge clk); #1; n++;
    end
    check("drain_in_time", 96'(n < bound), 96'(1));
  endtask

  bit seen;

  initial begin
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ctrl", 96'({BREQ, BWRITE, BDT_oe, if_ready, d_ready, bus_err, BSIZE}), 96'(0));
    check("rst_bus", 96'({BAD, BDT_o}), 96'(0));
    check("rst_rdata", 96'({if_rdata, d_rdata}), 96'(0));
    @(negedge clk) rst = 1'b1;

    // Single fetch, zero-wait acknowledge.
    if_fixed = 1'b1; if_dir_addr = 32'h0000_0100;
    resp_fixed = 1'b1; resp_fix_data = 32'h0050_0093; resp_wait_fix = 0;
    if_left = 1;
    wait_ready(1'b0, 20, seen);
    check("if_latency", 96'(cyc - if_issue_cyc), 96'(2));
    check("if_rdata_fixed", 96'(if_rdata), 96'(32'h0050_0093));
    @(posedge clk); #1;
    check("if_ready_width", 96'(if_ready), 96'(0));

    // Byte store.
    d_fixed = 1'b1;
    d_dir.addr = 32'h0000_2000; d_dir.size = 2'b00; d_dir.we = 1'b1; d_dir.wdata = 32'hDEAD_BEEF;
    repeat (2) @(posedge clk); #1;
    d_left = 1;
    wait_ready(1'b1, 20, seen);
    check("d_latency", 96'(cyc - d_issue_cyc), 96'(2));
    check("store_release", 96'({BDT_oe, BWRITE, BREQ}), 96'(0));

    // Both held: four data grants then a forced fetch, twice.
    repeat (3) @(posedge clk); #1;
    order = ""; if_fixed = 1'b0; d_fixed = 1'b0; resp_fixed = 1'b0;
    if_left = 2; d_left = 8;
    wait_drain(600);
    checks++;
    if (order != "DDDDIDDDDI") begin
      failures++;
      $display("FAIL grant_order actual=%s expected=DDDDIDDDDI", order);
    end

    // Ten-cycle acknowledge stall on a load.
    d_fixed = 1'b1;
    d_dir.addr = 32'h8000_0040; d_dir.size = 2'b10; d_dir.we = 1'b0; d_dir.wdata = 32'h0;
    resp_wait_fix = 10;
    repeat (2) @(posedge clk); #1;
    d_left = 1;
    wait_ready(1'b1, 40, seen);
    check("stall_latency", 96'(cyc - d_issue_cyc), 96'(12));

    // Reset in the middle of a fetch grant.
    if_fixed = 1'b1; if_dir_addr = 32'h0000_0300; resp_wait_fix = 50;
    repeat (2) @(posedge clk); #1;
    if_left = 1;
    for (int i = 0; i < 10 && !BREQ; i++) begin @(posedge clk); #1; end
    check("mid_grant_breq", 96'(BREQ), 96'(1));
    repeat (2) @(posedge clk);
    #2; resp_wait_fix = 0; rst = 1'b0;
    #1;
    check("rst_async", 96'({BREQ, if_ready, BAD}), 96'(0));
    repeat (2) @(negedge clk);
    check("rst_no_ready", 96'(if_ready), 96'(0));
    rst = 1'b1;
    wait_ready(1'b0, 20, seen);
    check("regrant_done", 96'(if_q.size()), 96'(0));

    // Randomized mixed traffic.
    if_fixed = 1'b0; d_fixed = 1'b0; resp_rand = 1'b1; gap_max = 3;
    repeat (2) @(posedge clk); #1;
    if_left = 40; d_left = 40;
    wait_drain(4000);

    check("bus_err_off", 96'(bus_err), 96'(0));
    check("nothing_outstanding", 96'(if_q.size() + d_q.size()), 96'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
